// File: rtl/mode_record.sv
// Record-mode writer: samples the note keys once per slot into a packed 4-bit-per-note song buffer
// and echoes the live key. Optional build macro: MODE_RECORD_ARM_EN (waits for first key before timing slots).
module mode_record #(
  parameter int SECOND    = 70000000,
  parameter int SONG_TIME = 61,
  parameter int LEN_W     = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [6:0]             key_in,
  input  logic                   rec_start,
  input  logic                   rec_stop,
  output logic [SONG_TIME*4-1:0] song_packed,
  output logic [LEN_W-1:0]       rec_len,
  output logic                   recording,
  output logic                   full,
  output logic [3:0]             note_to_play,
  output logic [6:0]             led_out
);

  localparam int SONG_W = SONG_TIME * 4;
  localparam int CTR_W  = $clog2(SECOND);
  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(SECOND - 1);
  localparam logic [LEN_W-1:0] PTR_LAST = LEN_W'(SONG_TIME - 1);
  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(SONG_TIME);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef MODE_RECORD_ARM_EN
    ARM  = 2'd1,
`endif
    REC  = 2'd2,
    FULL = 2'd3
  } state_t;

`ifdef MODE_RECORD_ARM_EN
  localparam state_t START_STATE = ARM;
`else
  localparam state_t START_STATE = REC;
`endif

  state_t             state, state_n;
  logic [CTR_W-1:0]   ctr, ctr_n;
  logic [LEN_W-1:0]   ptr, ptr_n;
  logic [LEN_W-1:0]   len_n;
  logic [SONG_W-1:0]  song_n;

  logic [6:0] key_s1, key_s2;
  logic       start_s1, start_s2, start_d;
  logic       stop_s1, stop_s2, stop_d;
  logic       start_edge, stop_edge;
  logic [3:0] enc;
  logic [6:0] led_n;
  logic       do_clear, do_write;

  // Two-flop synchronizers plus one delay flop for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_s1   <= '0;
      key_s2   <= '0;
      start_s1 <= 1'b0;
      start_s2 <= 1'b0;
      start_d  <= 1'b0;
      stop_s1  <= 1'b0;
      stop_s2  <= 1'b0;
      stop_d   <= 1'b0;
    end else begin
      key_s1   <= key_in;
      key_s2   <= key_s1;
      start_s1 <= rec_start;
      start_s2 <= start_s1;
      start_d  <= start_s2;
      stop_s1  <= rec_stop;
      stop_s2  <= stop_s1;
      stop_d   <= stop_s2;
    end
  end

  assign start_edge = start_s2 & ~start_d;
  assign stop_edge  = stop_s2 & ~stop_d;

  // Lowest pressed key wins; the downward loop lets lower bits overwrite higher ones.
  always_comb begin
    enc = 4'd0;
    for (int k = 6; k >= 0; k--) begin
      if (key_s2[k]) enc = 4'(k + 1);
    end
  end

  // Isolating the lowest set bit gives the LED for the same note the encoder picks.
  assign led_n = key_s2 & (~key_s2 + 7'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      note_to_play <= 4'd0;
      led_out      <= 7'd0;
    end else begin
      note_to_play <= enc;
      led_out      <= led_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ctr         <= '0;
      ptr         <= '0;
      rec_len     <= '0;
      song_packed <= '0;
    end else begin
      state       <= state_n;
      ctr         <= ctr_n;
      ptr         <= ptr_n;
      rec_len     <= len_n;
      song_packed <= song_n;
    end
  end

  // Start and stop are single-cycle edge events; stop beats start when both arrive together.
  always_comb begin
    state_n  = state;
    ctr_n    = ctr;
    ptr_n    = ptr;
    len_n    = rec_len;
    song_n   = song_packed;
    do_clear = 1'b0;
    do_write = 1'b0;
    case (state)
      IDLE, FULL: begin
        if (start_edge) do_clear = 1'b1;
      end
`ifdef MODE_RECORD_ARM_EN
      ARM: begin
        if (stop_edge) begin
          state_n = IDLE;
        end else if (start_edge) begin
          do_clear = 1'b1;
        end else if (enc != 4'd0) begin
          // The arming cycle is slot cycle 0, so the counter resumes at 1.
          state_n = REC;
          ctr_n   = CTR_W'(1);
        end
      end
`endif
      REC: begin
        if (start_edge && !stop_edge) begin
          do_clear = 1'b1;
        end else begin
          if (ctr == CTR_LAST) do_write = 1'b1;
          else                 ctr_n = ctr + CTR_W'(1);
          if (stop_edge) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // A write on the stop cycle still lands; filling the last slot takes precedence over IDLE.
    if (do_write) begin
      for (int i = 0; i < SONG_TIME; i++) begin
        if (ptr == LEN_W'(i)) song_n[4*i +: 4] = enc;
      end
      ctr_n = '0;
      if (ptr == PTR_LAST) begin
        state_n = FULL;
        len_n   = LEN_FULL;
      end else begin
        ptr_n = ptr + LEN_W'(1);
        len_n = rec_len + LEN_W'(1);
      end
    end

    if (do_clear) begin
      song_n  = '0;
      ptr_n   = '0;
      len_n   = '0;
      ctr_n   = '0;
      state_n = START_STATE;
    end
  end

  assign full = (state == FULL);
`ifdef MODE_RECORD_ARM_EN
  assign recording = (state == ARM) || (state == REC);
`else
  assign recording = (state == REC);
`endif

endmodule

// File: tb/tb_mode_record.sv
// Directed bench for mode_record with SECOND=4, SONG_TIME=4, LEN_W=3.
// Inputs change 1ns after a rising edge; outputs are sampled at that same point.
module tb_mode_record;
  localparam int SECOND    = 4;
  localparam int SONG_TIME = 4;
  localparam int LEN_W     = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  key_in;
  logic        rec_start;
  logic        rec_stop;
  logic [15:0] song_packed;
  logic [2:0]  rec_len;
  logic        recording;
  logic        full;
  logic [3:0]  note_to_play;
  logic [6:0]  led_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mode_record #(.SECOND(SECOND), .SONG_TIME(SONG_TIME), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .rec_start(rec_start), .rec_stop(rec_stop),
    .song_packed(song_packed), .rec_len(rec_len), .recording(recording), .full(full),
    .note_to_play(note_to_play), .led_out(led_out)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns 1ns after the edge where the start request takes effect.
  task automatic start_rec;
    rec_start = 1'b1;
    tick(2);
    rec_start = 1'b0;
    tick(1);
  endtask

  task automatic stop_rec;
    rec_stop = 1'b1;
    tick(3);
    rec_stop = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; key_in = 7'd0; rec_start = 1'b0; rec_stop = 1'b0;
    tick(2);
    checks++; if (song_packed !== 16'h0000) begin errors++; $display("FAIL rst_song: got %h expected %h", song_packed, 16'h0000); end
    checks++; if (rec_len !== 3'd0) begin errors++; $display("FAIL rst_len: got %0d expected %0d", rec_len, 0); end
    checks++; if (recording !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL rst_flags: got rec=%b full=%b expected 0 0", recording, full); end
    checks++; if (note_to_play !== 4'd0 || led_out !== 7'd0) begin errors++; $display("FAIL rst_echo: got note=%0d led=%b expected 0", note_to_play, led_out); end
    rst = 1'b0;
    tick(2);
    // Reset asserted mid-recording must clear everything without waiting for a clock.
    key_in = 7'b0000100;
    start_rec;
    tick(5);
    checks++; if (rec_len !== 3'd1 || recording !== 1'b1) begin errors++; $display("FAIL pre_rst_rec: got len=%0d rec=%b expected 1 1", rec_len, recording); end
    rst = 1'b1;
    #1;
    checks++; if (song_packed !== 16'h0000 || rec_len !== 3'd0) begin errors++; $display("FAIL async_rst_buf: got song=%h len=%0d expected 0000 0", song_packed, rec_len); end
    checks++; if (recording !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL async_rst_flags: got rec=%b full=%b expected 0 0", recording, full); end
    checks++; if (note_to_play !== 4'd0 || led_out !== 7'd0) begin errors++; $display("FAIL async_rst_echo: got note=%0d led=%b expected 0", note_to_play, led_out); end
    key_in = 7'd0;
    tick(1);
    rst = 1'b0;
    key_in = 7'b0001000;
    tick(3);
    checks++; if (note_to_play !== 4'd4 || led_out !== 7'b0001000) begin errors++; $display("FAIL idle_echo: got note=%0d led=%b expected 4 0001000", note_to_play, led_out); end
    key_in = 7'd0;
    tick(4);
    checks++; if (song_packed !== 16'h0000 || rec_len !== 3'd0 || recording !== 1'b0) begin errors++; $display("FAIL idle_no_rec: got song=%h len=%0d rec=%b expected 0000 0 0", song_packed, rec_len, recording); end
    checks++; if (note_to_play !== 4'd0) begin errors++; $display("FAIL idle_echo_off: got %0d expected 0", note_to_play); end
  endtask

  task automatic test_basic_record;
    key_in = 7'b0000100;
    tick(3);
    start_rec;
    checks++; if (recording !== 1'b1 || song_packed !== 16'h0000) begin errors++; $display("FAIL basic_start: got rec=%b song=%h expected 1 0000", recording, song_packed); end
    tick(15);
    checks++; if (rec_len !== 3'd3 || song_packed !== 16'h0333 || full !== 1'b0) begin errors++; $display("FAIL basic_3slots: got len=%0d song=%h full=%b expected 3 0333 0", rec_len, song_packed, full); end
    tick(1);
    checks++; if (song_packed !== 16'h3333 || rec_len !== 3'd4) begin errors++; $display("FAIL basic_full_buf: got song=%h len=%0d expected 3333 4", song_packed, rec_len); end
    checks++; if (full !== 1'b1 || recording !== 1'b0) begin errors++; $display("FAIL basic_full_flags: got full=%b rec=%b expected 1 0", full, recording); end
    key_in = 7'b0000001;
    tick(8);
    stop_rec;
    tick(2);
    checks++; if (song_packed !== 16'h3333 || rec_len !== 3'd4 || full !== 1'b1) begin errors++; $display("FAIL full_hold: got song=%h len=%0d full=%b expected 3333 4 1", song_packed, rec_len, full); end
  endtask

  task automatic test_stop_partial;
    key_in = 7'b0000001;
    tick(3);
    start_rec;
    checks++; if (song_packed !== 16'h0000 || rec_len !== 3'd0 || full !== 1'b0 || recording !== 1'b1) begin errors++; $display("FAIL restart_from_full: got song=%h len=%0d full=%b rec=%b expected 0000 0 0 1", song_packed, rec_len, full, recording); end
    tick(8);
    checks++; if (rec_len !== 3'd2 || song_packed !== 16'h0011) begin errors++; $display("FAIL partial_2slots: got len=%0d song=%h expected 2 0011", rec_len, song_packed); end
    rec_stop = 1'b1;
    tick(3);
    checks++; if (recording !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL stop_idle: got rec=%b full=%b expected 0 0", recording, full); end
    checks++; if (rec_len !== 3'd2 || song_packed !== 16'h0011) begin errors++; $display("FAIL stop_kept: got len=%0d song=%h expected 2 0011", rec_len, song_packed); end
    rec_stop = 1'b0;
    key_in = 7'd0;
    tick(6);
    checks++; if (rec_len !== 3'd2 || song_packed !== 16'h0011) begin errors++; $display("FAIL idle_frozen: got len=%0d song=%h expected 2 0011", rec_len, song_packed); end
    start_rec;
    checks++; if (song_packed !== 16'h0000 || rec_len !== 3'd0) begin errors++; $display("FAIL restart_clear: got song=%h len=%0d expected 0000 0", song_packed, rec_len); end
    stop_rec;
    checks++; if (recording !== 1'b0) begin errors++; $display("FAIL restart_stop: got rec=%b expected 0", recording); end
  endtask

  task automatic test_encode;
    key_in = 7'b1000010;
    tick(3);
    start_rec;
    key_in = 7'd0;
    tick(2);
    checks++; if (note_to_play !== 4'd2 || led_out !== 7'b0000010) begin errors++; $display("FAIL enc_prio: got note=%0d led=%b expected 2 0000010", note_to_play, led_out); end
    tick(1);
    checks++; if (note_to_play !== 4'd0 || led_out !== 7'd0) begin errors++; $display("FAIL enc_rest: got note=%0d led=%b expected 0 0", note_to_play, led_out); end
    tick(1);
    checks++; if (rec_len !== 3'd1 || song_packed !== 16'h0000) begin errors++; $display("FAIL rest_slot: got len=%0d song=%h expected 1 0000", rec_len, song_packed); end
    key_in = 7'b1000010;
    tick(2);
    checks++; if (note_to_play !== 4'd0) begin errors++; $display("FAIL echo_latency: got %0d expected 0", note_to_play); end
    tick(1);
    checks++; if (note_to_play !== 4'd2 || led_out !== 7'b0000010) begin errors++; $display("FAIL echo_3clk: got note=%0d led=%b expected 2 0000010", note_to_play, led_out); end
    tick(1);
    checks++; if (rec_len !== 3'd2 || song_packed !== 16'h0020) begin errors++; $display("FAIL prio_slot: got len=%0d song=%h expected 2 0020", rec_len, song_packed); end
  endtask

  task automatic test_simultaneous;
    // Entered while recording, just after slot 1 was written.
    rec_start = 1'b1;
    rec_stop  = 1'b1;
    key_in    = 7'b1000000;
    tick(3);
    checks++; if (recording !== 1'b0 || rec_len !== 3'd2 || song_packed !== 16'h0020) begin errors++; $display("FAIL start_stop_tie: got rec=%b len=%0d song=%h expected 0 2 0020", recording, rec_len, song_packed); end
    checks++; if (note_to_play !== 4'd7 || led_out !== 7'b1000000) begin errors++; $display("FAIL enc_note7: got note=%0d led=%b expected 7 1000000", note_to_play, led_out); end
    rec_start = 1'b0;
    rec_stop  = 1'b0;
    key_in    = 7'b0010000;
    tick(3);
    start_rec;
    tick(1);
    rec_stop = 1'b1;
    tick(3);
    checks++; if (recording !== 1'b0 || rec_len !== 3'd1 || song_packed !== 16'h0005) begin errors++; $display("FAIL stop_on_write: got rec=%b len=%0d song=%h expected 0 1 0005", recording, rec_len, song_packed); end
    rec_stop = 1'b0;
    tick(5);
    checks++; if (rec_len !== 3'd1 || song_packed !== 16'h0005 || full !== 1'b0) begin errors++; $display("FAIL after_stop_write: got len=%0d song=%h full=%b expected 1 0005 0", rec_len, song_packed, full); end
  endtask

  task automatic test_arm;
    key_in = 7'd0;
    tick(3);
    rec_start = 1'b1;
    tick(2);
    checks++; if (recording !== 1'b0) begin errors++; $display("FAIL rec_not_yet: got %b expected 0", recording); end
    rec_start = 1'b0;
    tick(1);
    checks++; if (recording !== 1'b1 || rec_len !== 3'd0 || song_packed !== 16'h0000) begin errors++; $display("FAIL start_entry: got rec=%b len=%0d song=%h expected 1 0 0000", recording, rec_len, song_packed); end
`ifdef MODE_RECORD_ARM_EN
    tick(17);
    checks++; if (rec_len !== 3'd0 || recording !== 1'b1 || song_packed !== 16'h0000) begin errors++; $display("FAIL arm_wait: got len=%0d rec=%b song=%h expected 0 1 0000", rec_len, recording, song_packed); end
    key_in = 7'b0010000;
    tick(5);
    checks++; if (rec_len !== 3'd0 || recording !== 1'b1) begin errors++; $display("FAIL arm_before_write: got len=%0d rec=%b expected 0 1", rec_len, recording); end
    tick(1);
    checks++; if (rec_len !== 3'd1 || song_packed !== 16'h0005) begin errors++; $display("FAIL arm_first_slot: got len=%0d song=%h expected 1 0005", rec_len, song_packed); end
`else
    tick(3);
    checks++; if (rec_len !== 3'd0) begin errors++; $display("FAIL noarm_before_write: got %0d expected 0", rec_len); end
    tick(1);
    checks++; if (rec_len !== 3'd1 || song_packed !== 16'h0000 || recording !== 1'b1) begin errors++; $display("FAIL noarm_rest_slot: got len=%0d song=%h rec=%b expected 1 0000 1", rec_len, song_packed, recording); end
`endif
  endtask

  initial begin
    test_reset;
    test_basic_record;
    test_stop_partial;
    test_encode;
    test_simultaneous;
    test_arm;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
